// File: rtl/mem_access_unit.sv
// Load/store unit: turns byte-addressed B/H/W requests into word-memory cycles,
// splitting accesses that straddle a word boundary into two consecutive cycles.
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state;
  logic                  we_r;
  logic                  err_r;
  logic [2:0]            funct3_r;
  logic [ADDR_WIDTH+1:0] addr_r;
  logic [31:0]           wdata_r;
  logic [31:0]           rbuf0;
  logic [31:0]           rbuf1;

  logic [1:0]            off;
  logic [2:0]            size;
  logic [3:0]            size_mask;
  logic                  split;
  logic [ADDR_WIDTH-1:0] word0;
  logic [ADDR_WIDTH-1:0] word1;
  logic [63:0]           wdata_ext;
  logic [7:0]            mask_ext;
  logic [31:0]           rdata_sh;
  logic [31:0]           load_data;
  logic                  req_err;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  assign req_err = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                   (req_we && req_funct3[2]);

  always_comb begin
    off = addr_r[1:0];
    case (funct3_r[1:0])
      2'b00:   begin size = 3'd1; size_mask = 4'b0001; end
      2'b01:   begin size = 3'd2; size_mask = 4'b0011; end
      default: begin size = 3'd4; size_mask = 4'b1111; end
    endcase
    split     = ({1'b0, off} + size) > 3'd4;
    word0     = addr_r[ADDR_WIDTH+1:2];
    word1     = word0 + ADDR_WIDTH'(1);
    wdata_ext = {32'b0, wdata_r} << {off, 3'b000};
    mask_ext  = {4'b0, size_mask} << off;
    // Byte lanes of both halves concatenated, then right-aligned to the access offset.
    rdata_sh  = 32'({rbuf1, rbuf0} >> {off, 3'b000});
    case (funct3_r)
      3'b000:  load_data = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      3'b001:  load_data = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b010:  load_data = rdata_sh;
      3'b100:  load_data = {24'b0, rdata_sh[7:0]};
      3'b101:  load_data = {16'b0, rdata_sh[15:0]};
      default: load_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      we_r     <= 1'b0;
      err_r    <= 1'b0;
      funct3_r <= '0;
      addr_r   <= '0;
      wdata_r  <= '0;
      rbuf0    <= '0;
      rbuf1    <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          we_r     <= req_we;
          err_r    <= req_err;
          funct3_r <= req_funct3;
          addr_r   <= req_addr[ADDR_WIDTH+1:0];
          wdata_r  <= req_wdata[31:0];
          state    <= req_err ? S_DONE : S_ACC0;
        end
        S_ACC0: begin
          rbuf0 <= mem_rdata[31:0];
          state <= split ? S_ACC1 : S_DONE;
        end
        S_ACC1: begin
          rbuf1 <= mem_rdata[31:0];
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write enable is gated by rst combinationally so a reset mid-access drops that cycle's write.
  always_comb begin
    req_ready  = (state == S_IDLE) && !rst;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    mem_we     = 1'b0;
    case (state)
      S_ACC0: begin
        mem_addr  = word0;
        mem_wdata = DATA_WIDTH'(wdata_ext[31:0]);
        mem_wmask = we_r ? mask_ext[3:0] : 4'b0000;
        mem_we    = we_r && !rst;
      end
      S_ACC1: begin
        mem_addr  = word1;
        mem_wdata = DATA_WIDTH'(wdata_ext[63:32]);
        mem_wmask = we_r ? mask_ext[7:4] : 4'b0000;
        mem_we    = we_r && !rst;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_r;
        resp_rdata = (we_r || err_r) ? '0 : DATA_WIDTH'(load_data);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level reference memory, directed cases then random traffic.
module tb_mem_access_unit;
  localparam int unsigned AW = 15;
  localparam int unsigned NW = 1 << AW;
  localparam int unsigned NB = NW * 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  logic [31:0] mem [0:NW-1];
  logic [7:0]  rb  [0:NB-1];
  bit          mem_init_done = 1'b0;
  int          checks = 0;
  int          errors = 0;

  mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int unsigned w);
    return 32'(w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int unsigned w = 0; w < NW; w++) mem[w] = init_word(w);
      mem_init_done = 1'b1;
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_wmask[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request through the unit; expectations come from byte-level reasoning over rb.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd);
    int unsigned ba, sz, nw, cyc, b, widx, idx;
    logic [AW-1:0] waddr [2];
    logic [3:0]    emask [2];
    logic [31:0]   edata [2];
    logic [31:0]   val, exp_rd;
    bit            err, got;
    err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    ba  = a & (NB - 1);
    waddr[0] = AW'(ba >> 2);
    waddr[1] = AW'(((ba + sz - 1) & (NB - 1)) >> 2);
    nw = (waddr[0] == waddr[1]) ? 1 : 2;
    emask[0] = '0; emask[1] = '0; edata[0] = '0; edata[1] = '0;
    val = '0;
    for (int i = 0; i < int'(sz); i++) begin
      b = (ba + i) & (NB - 1);
      widx = (AW'(b >> 2) == waddr[0]) ? 0 : 1;
      emask[widx][b & 3] = 1'b1;
      edata[widx][8*(b & 3) +: 8] = wd[8*i +: 8];
      val[8*i +: 8] = rb[b];
    end
    if (err || we) exp_rd = '0;
    else case (f3)
      3'b000:  exp_rd = {{24{val[7]}}, val[7:0]};
      3'b001:  exp_rd = {{16{val[15]}}, val[15:0]};
      3'b100:  exp_rd = {24'b0, val[7:0]};
      3'b101:  exp_rd = {16'b0, val[15:0]};
      default: exp_rd = val;
    endcase

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_we = $urandom_range(0, 1); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    cyc = 0; got = 1'b0; rd = '0;
    while (!got && cyc < 6) begin
      @(negedge clk); cyc++;
      chk("req_ready_busy", req_ready, 0);
      if (resp_valid) begin
        got = 1'b1;
        chk("resp_err", resp_err, err);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("mem_we_done", mem_we, 0);
        rd = resp_rdata;
        req_valid = 1'b0;
      end else if (cyc <= 2) begin
        idx = cyc - 1;
        chk("mem_addr", mem_addr, waddr[idx]);
        chk("mem_we", mem_we, we && !err);
        if (we) begin
          chk("mem_wmask", mem_wmask, emask[idx]);
          for (int l = 0; l < 4; l++)
            if (emask[idx][l]) chk("mem_wdata_lane", mem_wdata[8*l +: 8], edata[idx][8*l +: 8]);
        end
      end
    end
    req_valid = 1'b0;
    chk("resp_seen", got, 1);
    chk("latency", cyc, err ? 1 : nw + 1);
    if (we && !err)
      for (int i = 0; i < int'(sz); i++) rb[(ba + i) & (NB - 1)] = wd[8*i +: 8];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a, w;
    logic [2:0]  f3;
    logic        we;
    int unsigned r;
    logic [2:0]  legal [5];
    legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010; legal[3] = 3'b100; legal[4] = 3'b101;
    for (int unsigned bb = 0; bb < NB; bb++) begin
      w = init_word(bb >> 2);
      rb[bb] = w[8*(bb & 3) +: 8];
    end

    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    #1 chk("rel_req_ready", req_ready, 1);

    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, rd);
    do_req(1, 3'b000, 32'h13, 32'h000000AB, rd);
    do_req(0, 3'b000, 32'h13, 32'h0, rd);       chk("tp_lb", rd, 32'hFFFFFFAB);
    do_req(0, 3'b100, 32'h13, 32'h0, rd);       chk("tp_lbu", rd, 32'h000000AB);
    do_req(1, 3'b010, 32'h0C, 32'h44332211, rd);
    do_req(1, 3'b010, 32'h10, 32'h88776655, rd);
    do_req(0, 3'b010, 32'h0E, 32'h0, rd);       chk("tp_lw_split", rd, 32'h66554433);
    do_req(0, 3'b001, 32'h0E, 32'h0, rd);       chk("tp_lh_0e", rd, 32'h00004433);
    do_req(0, 3'b001, 32'h0F, 32'h0, rd);       chk("tp_lh_0f", rd, 32'h00005544);
    do_req(1, 3'b001, 32'h1F, 32'h00001234, rd);
    do_req(0, 3'b101, 32'h1F, 32'h0, rd);       chk("tp_lhu_1f", rd, 32'h00001234);
    do_req(1, 3'b010, NB - 4, 32'hA1B2C3D4, rd);
    do_req(1, 3'b010, 32'h0, 32'h0F1E2D3C, rd);
    do_req(0, 3'b010, NB - 2, 32'h0, rd);       chk("tp_wrap", rd, 32'h2D3CA1B2);
    do_req(0, 3'b011, 32'h20, 32'h0, rd);
    do_req(1, 3'b100, 32'h20, 32'h55, rd);

    // Reset during the first half of a split store: nothing may be written, no response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h22; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("acc0_mem_we_pre", mem_we, 1);
    rst = 1'b1;
    #1 chk("acc0_mem_we_rst", mem_we, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_resp", resp_valid, 0);
      chk("rst_no_ready", req_ready, 0);
    end
    rst = 1'b0;
    #1 chk("post_rst_ready", req_ready, 1);
    do_req(0, 3'b010, 32'h20, 32'h0, rd);
    do_req(0, 3'b010, 32'h24, 32'h0, rd);

    for (int n = 0; n < 300; n++) begin
      we = $urandom_range(0, 1);
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : legal[$urandom_range(0, 4)];
      r  = $urandom_range(0, 3);
      a  = $urandom;
      if (r == 0)      a = (a & ~(NB - 1)) | $urandom_range(0, 63);
      else if (r == 1) a = (a & ~(NB - 1)) | (NB - 16 + $urandom_range(0, 15));
      do_req(we, f3, a, $urandom, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit sitting between the pipeline MEM stage and the word-organised data memory (combinational read, byte-masked synchronous write). It accepts one load or store per request, converts the byte address and funct3 into word address, byte lanes and write mask, and returns sign- or zero-extended load data. Accesses that cross a word boundary are split into two consecutive memory cycles by an internal state machine.

## Interface
- ADDR_WIDTH, 15, word-address width of the data memory.
- DATA_WIDTH, 32, memory word width; only 32 is supported.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- req_addr  in  32  byte address; bits above ADDR_WIDTH+1 ignored.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse, request complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; illegal funct3.
- mem_addr  out  ADDR_WIDTH  word address to memory.
- mem_wdata  out  32  lane-positioned store data.
- mem_wmask  out  4  byte write enables, bit i = byte lane i.
- mem_we  out  1  memory write enable.
- mem_rdata  in  32  combinational read data for mem_addr.

## Operation
- States: IDLE, ACC0, ACC1, DONE.
- IDLE: req_ready=1; on req_valid latch we, funct3, addr, wdata; go ACC0 (or DONE with err if funct3 illegal: 011, 110, 111, or store with funct3 bit2 set).
- Size: B=1, H=2, W=4 bytes; off = addr[1:0]; split = off+size > 4.
- Store lanes: 64-bit wdata_ext = wdata << 8*off; 8-bit mask_ext = size-mask << off. ACC0 drives low 32/4 bits, ACC1 high 32/4 bits.
- ACC0: mem_addr = addr[ADDR_WIDTH+1:2]; mem_we=we; capture mem_rdata into rbuf0; go ACC1 if split else DONE.
- ACC1: mem_addr = ACC0 address + 1, modulo 2^ADDR_WIDTH (wraps to 0); mem_we=we; capture rbuf1; go DONE.
- DONE: resp_valid=1; load data = ({rbuf1, rbuf0} >> 8*off) truncated to size, sign-extended for B/H, zero-extended for BU/HU/W; go IDLE.
- mem_we is 0 in IDLE/DONE, never asserted with mem_wmask=0, and never asserted for errors or loads.
- No response back-pressure: pipeline must sample resp_* in the DONE cycle.

## Timing
- Request accepted at edge T (req_valid && req_ready).
- Aligned access: memory cycle T+1, resp_valid in cycle T+2; req_ready low T+1..T+2.
- Split access: memory cycles T+1, T+2; resp_valid in T+3.
- Error: resp_valid in T+1, no memory cycle.
- Back-to-back: new request accepted in the cycle after DONE; throughput 1 per 3 (aligned).
- Reset values: state IDLE, req_ready 0 while rst high then 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_we 0, mem_wmask 0, mem_addr 0, mem_wdata 0.
- mem_we gated combinationally by !rst: reset in ACC0/ACC1 suppresses that cycle's write; a split store reset between halves leaves only the first half written and produces no resp_valid.
- req_* ignored outside IDLE and while rst high.

## Test plan
- SW addr 0x10 data 0xDEADBEEF -> T+1: mem_addr 4, mem_wmask 1111, mem_we 1, mem_wdata 0xDEADBEEF; T+2: resp_valid, rdata 0, err 0.
- SB addr 0x13 data 0x000000AB -> mem_wmask 1000, mem_wdata[31:24]=0xAB; then LB 0x13 -> 0xFFFFFFAB, LBU 0x13 -> 0x000000AB.
- Word3=0x44332211, word4=0x88776655; LW addr 0x0E -> mem_addr 3 then 4, resp at T+3 with 0x66554433; LH 0x0E -> 0x00004433, LH 0x0F -> 0x00005544.
- SH addr 0x1F data 0x1234 -> cycle1 addr 7 mask 1000 wdata[31:24]=0x34; cycle2 addr 8 mask 0001 wdata[7:0]=0x12; LHU 0x1F reads back 0x00001234.
- LW at byte addr 4·2^ADDR_WIDTH−2 -> second access mem_addr 0 (wrap), data assembled from last word high half and word 0 low half.
- Load funct3 011 -> resp_err 1 at T+1, no mem_we; rst asserted during ACC0 of split SW -> no write that cycle, no resp_valid, req_ready 1 after rst release.
